// File: rtl/stream_arbiter.sv
// Grant generator for the streaming crossbar: one round-robin arbiter per master port
// with packet locking, producing the one-hot grant matrix and per-source ready.

module stream_arbiter_master #(
  parameter int S   = 5,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [S-1:0]   i_req,
  input  logic [S-1:0]   i_valid,
  input  logic [S-1:0]   i_last,
  input  logic           i_ready,
  output logic [S-1:0]   o_grant,
  output logic [IDW-1:0] o_id,
  output logic           o_valid,
  output logic           o_last
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]     r_state;
  logic [S-1:0]   r_grant;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_ptr;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic           w_beat;

  // grant row is one-hot while locked, so a masked OR selects the owner's signals
  assign o_valid = |(r_grant & i_valid);
  assign o_last  = |(r_grant & i_last);
  assign w_beat  = o_valid & i_ready;
  assign o_grant = r_grant;
  assign o_id    = r_id;

  // first requester strictly after the pointer, wrapping S-1 -> 0
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= S; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % S);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_ptr   <= IDW'(S - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= S'(1) << w_win;
            r_id    <= w_win;
            r_ptr   <= w_win;
            r_state <= ST_LOCK;
          end
        end
        default: begin
          if (w_beat && o_last) begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

module stream_arbiter #(
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [S_DATA_COUNT-1:0]            s_valid_i,
  input  logic [S_DATA_COUNT-1:0]            s_last_i,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  output logic [S_DATA_COUNT-1:0]            s_ready_o,
  input  logic [M_DATA_COUNT-1:0]            m_ready_i,
  output logic [M_DATA_COUNT-1:0]            m_valid_o,
  output logic [M_DATA_COUNT-1:0]            m_last_o,
  output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
  output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o
);

  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_grant;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_req;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] w_id;
  logic [S_DATA_COUNT-1:0]                   w_locked;
  logic [S_DATA_COUNT-1:0]                   w_ready;

  // a source owned by any master is hidden from every arbiter
  always_comb begin
    w_locked = '0;
    w_ready  = '0;
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      w_locked = w_locked | w_grant[j];
      w_ready  = w_ready | (w_grant[j] & {S_DATA_COUNT{m_ready_i[j]}});
    end
  end

  // out-of-range destinations match no master and simply stall
  always_comb begin
    w_req = '0;
    for (int j = 0; j < M_DATA_COUNT; j++)
      for (int i = 0; i < S_DATA_COUNT; i++)
        w_req[j][i] = s_valid_i[i] & ~w_locked[i] &
                      (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(j));
  end

  for (genvar g = 0; g < M_DATA_COUNT; g++) begin : g_mst
    stream_arbiter_master #(
      .S   (S_DATA_COUNT),
      .IDW (T_ID___WIDTH)
    ) u_mst (
      .clk     (clk),
      .rst     (rst),
      .i_req   (w_req[g]),
      .i_valid (s_valid_i),
      .i_last  (s_last_i),
      .i_ready (m_ready_i[g]),
      .o_grant (w_grant[g]),
      .o_id    (w_id[g]),
      .o_valid (m_valid_o[g]),
      .o_last  (m_last_o[g])
    );
  end

  assign grant_o   = w_grant;
  assign m_id_o    = w_id;
  assign s_ready_o = w_ready;

endmodule
